// File: rtl/store_buffer.sv
// MEM-stage store buffer: encodes stores into lane-aligned bus writes and
// queues them in a small circular FIFO drained in order by the bus.
module store_buffer #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [1:0]  st_ctrl,
   output logic        st_ready,
   output logic        st_exc,
   output logic        bus_req,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byteen,
   input  logic        bus_ack,
   output logic        empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Entries live in flops: the head must be visible the cycle after enqueue.
   logic [31:0] addr_mem [DEPTH];
   logic [31:0] data_mem [DEPTH];
   logic [3:0]  be_mem   [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   logic        enq;
   logic        deq;
   logic [31:0] enc_addr;
   logic [31:0] enc_data;
   logic [3:0]  enc_be;

   assign st_exc = st_valid &&
                   ((st_ctrl == 2'b00 && st_addr[1:0] != 2'b00) ||
                    (st_ctrl == 2'b01 && st_addr[0]));

   // No bypass: a full buffer refuses even when the head drains this cycle.
   assign st_ready = (count_q < FULL);
   assign bus_req  = (count_q != '0);
   assign empty    = (count_q == '0);

   assign enq = st_valid && st_ready && !st_exc && (st_ctrl != 2'b11);
   assign deq = bus_req && bus_ack;

   always_comb begin
      enc_addr = {st_addr[31:2], 2'b00};
      enc_data = st_data;
      enc_be   = 4'b1111;
      case (st_ctrl)
         2'b01: begin
            enc_data = {2{st_data[15:0]}};
            enc_be   = st_addr[1] ? 4'b1100 : 4'b0011;
         end
         2'b10: begin
            enc_data = {4{st_data[7:0]}};
            enc_be   = 4'b0001 << st_addr[1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry contents need no reset; stale slots are never presented.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
         if (enq && wr_ptr_q == PW'(gi)) begin
            addr_mem[gi] <= enc_addr;
            data_mem[gi] <= enc_data;
            be_mem[gi]   <= enc_be;
         end
      end
   end

   assign bus_addr   = bus_req ? addr_mem[rd_ptr_q] : 32'h0;
   assign bus_wdata  = bus_req ? data_mem[rd_ptr_q] : 32'h0;
   assign bus_byteen = bus_req ? be_mem[rd_ptr_q]   : 4'h0;
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered store entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port st_valid  input  1  MEM-stage store request present.
REQ-005 SHALL have port st_addr  input  32  byte address of store.
REQ-006 SHALL have port st_data  input  32  register data, right-justified.
REQ-007 SHALL have port st_ctrl  input  2  width select: 00 word, 01 half, 10 byte, 11 none.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port st_exc  output  1  address-error-on-store (misaligned), combinational.
REQ-010 SHALL have port bus_req  output  1  head entry valid on bus.
REQ-011 SHALL have port bus_addr  output  32  word-aligned address of head entry.
REQ-012 SHALL have port bus_wdata  output  32  lane-aligned write data of head entry.
REQ-013 SHALL have port bus_byteen  output  4  byte-lane enables of head entry.
REQ-014 SHALL have port bus_ack  input  1  bus accepts head entry this cycle.
REQ-015 SHALL have port empty  output  1  no entries buffered (load-ordering check).

Function
REQ-016 SHALL assert st_exc when st_valid and (st_ctrl=00 and st_addr[1:0]!=0, or st_ctrl=01 and st_addr[0]=1), independent of st_ready.
REQ-017 SHALL enqueue on an edge iff st_valid & st_ready & !st_exc & st_ctrl!=11; st_ctrl=11 is a no-op.
REQ-018 SHALL encode word: byteen 1111, wdata = st_data.
REQ-019 SHALL encode half: byteen 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata = {st_data[15:0], st_data[15:0]}.
REQ-020 SHALL encode byte: byteen = 0001 << addr[1:0], wdata = {4{st_data[7:0]}}.
REQ-021 SHALL store bus_addr as {st_addr[31:2], 2'b00}.
REQ-022 SHALL keep entries in a circular FIFO: write pointer, read pointer (log2 DEPTH bits, wrap DEPTH-1 -> 0) and count (0..DEPTH).
REQ-023 SHALL drive st_ready = (count < DEPTH); no bypass, so a full buffer with simultaneous bus_ack still refuses that cycle.
REQ-024 SHALL drive bus_req = (count != 0) and empty = (count == 0).
REQ-025 SHALL present head entry on bus_addr/bus_wdata/bus_byteen whenever bus_req=1, held stable until the edge where bus_ack=1.
REQ-026 SHALL drive bus_addr, bus_wdata, bus_byteen to 0 when bus_req=0.
REQ-027 SHALL dequeue head on edge where bus_req & bus_ack; bus_ack with bus_req=0 is ignored.
REQ-028 SHALL, on simultaneous enqueue and dequeue, leave count unchanged and advance both pointers.
REQ-029 SHALL have latency 1: store enqueued at edge N into an empty buffer gives bus_req=1 in cycle after N; no combinational path st_* -> bus_*.
REQ-030 SHALL issue bus writes in enqueue order, one per ack, back-to-back ack drains one entry per cycle.

Reset
REQ-031 SHALL, on an edge with reset=1, clear count and both pointers, discarding all entries including one currently on the bus.
REQ-032 SHALL output after reset: bus_req 0, bus_addr/bus_wdata/bus_byteen 0, st_ready 1, empty 1; st_exc follows inputs.
REQ-033 SHALL ignore st_valid and bus_ack on reset edges.

Verification
REQ-034 Bench SHALL: sb addr 0x0000_1003, data 0x0000_00A5, idle bus -> next cycle bus_req=1, bus_addr 0x0000_1000, byteen 1000, wdata 0xA5A5_A5A5.
REQ-035 Bench SHALL: sh addr 0x2, data 0x1234_BEEF -> byteen 1100, wdata 0xBEEF_BEEF, bus_addr 0x0; sw addr 0x6 -> st_exc=1, count unchanged.
REQ-036 Bench SHALL: 3 stores, bus_ack=0, DEPTH=2 -> st_ready low after 2nd; third held by MEM; then ack each cycle -> order 1,2,3, empty=1 after last.
REQ-037 Bench SHALL: full buffer with bus_ack=1 and st_valid=1 same cycle -> no enqueue that edge; count 1 after; st_ready=1 next cycle.
REQ-038 Bench SHALL: bus_req held with bus_ack=0 for 5 cycles -> bus_addr/wdata/byteen unchanged each cycle.
REQ-039 Bench SHALL: reset pulse while 2 entries pending and bus_req=1 -> next cycle bus_req=0, empty=1, st_ready=1, later ack produces no dequeue.
